alu_issue_stage: RTL and testbench

- Single-entry ID/EX pipeline register that sits directly upstream of alu32.
- Takes decoded RV32I instruction fields from the decode stage, selects the ALU operands, and generates the 4-bit ALU select code.
- Presents a registered {X, Y, select} bundle to alu32 through a valid/ready handshake, with stall and flush support.
- Flags unsupported opcodes and encodings as illegal.

---
 rtl/alu_issue_stage_pkg.sv | 50 +++++
 rtl/alu_issue_stage_decode.sv | 68 ++++++
 rtl/alu_issue_stage.sv | 103 ++++++++++
 tb/tb_alu_issue_stage.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_stage_pkg.sv
// Shared constants and types for the ALU issue stage and its alu32 consumer.
// Holds ALU select codes, RV32I opcodes, funct7 values and the decode control payload.
package alu_issue_stage_pkg;

  localparam int unsigned SEL_W = 4;
  localparam int unsigned OPC_W = 7;
  localparam int unsigned F3_W  = 3;
  localparam int unsigned F7_W  = 7;
  localparam int unsigned REG_W = 5;

  localparam logic [SEL_W-1:0] ALU_ADD    = 4'b0000;
  localparam logic [SEL_W-1:0] ALU_SUB    = 4'b1000;
  localparam logic [SEL_W-1:0] ALU_SLL    = 4'b0001;
  localparam logic [SEL_W-1:0] ALU_SLT    = 4'b0010;
  localparam logic [SEL_W-1:0] ALU_SLTU   = 4'b0011;
  localparam logic [SEL_W-1:0] ALU_XOR    = 4'b0100;
  localparam logic [SEL_W-1:0] ALU_SRL    = 4'b0101;
  localparam logic [SEL_W-1:0] ALU_SRA    = 4'b1101;
  localparam logic [SEL_W-1:0] ALU_OR     = 4'b0110;
  localparam logic [SEL_W-1:0] ALU_AND    = 4'b0111;
  localparam logic [SEL_W-1:0] ALU_PASS_Y = 4'b1111;

  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;

  localparam logic [F7_W-1:0] F7_BASE = 7'b0000000;
  localparam logic [F7_W-1:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {X_RS1, X_PC, X_ZERO} x_src_e;
  typedef enum logic [1:0] {Y_RS2, Y_IMM, Y_LINK, Y_ZERO} y_src_e;

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    x_src_e           x_src;
    y_src_e           y_src;
    logic             illegal;
  } dec_ctrl_t;

  function automatic logic [SEL_W-1:0] mk_sel(input logic alt, input logic [F3_W-1:0] f3);
    return {alt, f3};
  endfunction

endpackage

// File: rtl/alu_issue_stage_decode.sv
// Combinational ALU control decode: maps opcode/funct3/funct7 to the ALU
// select code, operand source selects and the illegal-encoding flag.
module alu_ctrl_decode
  import alu_issue_stage_pkg::*;
(
  input  logic [OPC_W-1:0] i_opcode,
  input  logic [F3_W-1:0]  i_funct3,
  input  logic [F7_W-1:0]  i_funct7,
  output dec_ctrl_t        o_ctrl_c
);

  logic w_f7_base;
  logic w_f7_alt;

  assign w_f7_base = (i_funct7 == F7_BASE);
  assign w_f7_alt  = (i_funct7 == F7_ALT);

  always_comb begin
    o_ctrl_c.sel     = ALU_ADD;
    o_ctrl_c.x_src   = X_ZERO;
    o_ctrl_c.y_src   = Y_ZERO;
    o_ctrl_c.illegal = 1'b0;
    case (i_opcode)
      OPC_OP: begin
        o_ctrl_c.x_src   = X_RS1;
        o_ctrl_c.y_src   = Y_RS2;
        o_ctrl_c.sel     = mk_sel(i_funct7[5], i_funct3);
        o_ctrl_c.illegal = !(w_f7_base ||
                             (w_f7_alt && (i_funct3 == 3'b000 || i_funct3 == 3'b101)));
      end
      OPC_OP_IMM: begin
        // funct7 is immediate payload except for the shift encodings
        o_ctrl_c.x_src = X_RS1;
        o_ctrl_c.y_src = Y_IMM;
        o_ctrl_c.sel   = mk_sel((i_funct3 == 3'b101) && i_funct7[5], i_funct3);
        case (i_funct3)
          3'b001:  o_ctrl_c.illegal = !w_f7_base;
          3'b101:  o_ctrl_c.illegal = !(w_f7_base || w_f7_alt);
          default: o_ctrl_c.illegal = 1'b0;
        endcase
      end
      OPC_LUI: begin
        o_ctrl_c.x_src = X_ZERO;
        o_ctrl_c.y_src = Y_IMM;
        o_ctrl_c.sel   = ALU_PASS_Y;
      end
      OPC_AUIPC: begin
        o_ctrl_c.x_src = X_PC;
        o_ctrl_c.y_src = Y_IMM;
      end
      OPC_JAL, OPC_JALR: begin
        o_ctrl_c.x_src = X_PC;
        o_ctrl_c.y_src = Y_LINK;
      end
      OPC_LOAD, OPC_STORE: begin
        o_ctrl_c.x_src = X_RS1;
        o_ctrl_c.y_src = Y_IMM;
      end
      OPC_BRANCH: begin
        o_ctrl_c.x_src = X_RS1;
        o_ctrl_c.y_src = Y_RS2;
        o_ctrl_c.sel   = ALU_SUB;
      end
      default: o_ctrl_c.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Single-entry ID/EX register feeding alu32: operand select, ALU select
// generation, valid/ready handshake with stall and flush.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned RESET_PC_LINK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPC_W-1:0] opcode,
  input  logic [F3_W-1:0]  funct3,
  input  logic [F7_W-1:0]  funct7,
  input  logic [REG_W-1:0] rd,
  input  logic [XLEN-1:0]  rs1_val,
  input  logic [XLEN-1:0]  rs2_val,
  input  logic [XLEN-1:0]  imm,
  input  logic [XLEN-1:0]  pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  alu_x,
  output logic [XLEN-1:0]  alu_y,
  output logic [SEL_W-1:0] alu_sel,
  output logic [REG_W-1:0] out_rd,
  output logic             illegal
);

  dec_ctrl_t        w_ctrl;
  logic [XLEN-1:0]  w_x;
  logic [XLEN-1:0]  w_y;
  logic             w_load;

  logic             r_valid;
  logic [XLEN-1:0]  r_x;
  logic [XLEN-1:0]  r_y;
  logic [SEL_W-1:0] r_sel;
  logic [REG_W-1:0] r_rd;
  logic             r_illegal;

  alu_ctrl_decode u_decode (
    .i_opcode (opcode),
    .i_funct3 (funct3),
    .i_funct7 (funct7),
    .o_ctrl_c (w_ctrl)
  );

  always_comb begin
    w_x = '0;
    case (w_ctrl.x_src)
      X_RS1:   w_x = rs1_val;
      X_PC:    w_x = pc;
      default: w_x = '0;
    endcase
  end

  always_comb begin
    w_y = '0;
    case (w_ctrl.y_src)
      Y_RS2:   w_y = rs2_val;
      Y_IMM:   w_y = imm;
      Y_LINK:  w_y = XLEN'(RESET_PC_LINK);
      default: w_y = '0;
    endcase
  end

  assign in_ready = !r_valid || out_ready;
  assign w_load   = in_valid && in_ready;

  // Flush kills both the held and the incoming bundle; data may stay stale.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
      r_sel     <= ALU_ADD;
      r_rd      <= '0;
      r_illegal <= 1'b0;
    end else if (flush) begin
      r_valid   <= 1'b0;
      r_illegal <= 1'b0;
    end else if (w_load) begin
      r_valid   <= 1'b1;
      r_x       <= w_x;
      r_y       <= w_y;
      r_sel     <= w_ctrl.sel;
      r_rd      <= rd;
      r_illegal <= w_ctrl.illegal;
    end else if (out_ready) begin
      r_valid   <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign alu_x     = r_x;
  assign alu_y     = r_y;
  assign alu_sel   = r_sel;
  assign out_rd    = r_rd;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed encodings, stall, flush,
// reset, then randomized traffic against an instruction-level reference model.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [31:0] rs1_val, rs2_val, imm, pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_x, alu_y;
  logic [3:0]  alu_sel;
  logic [4:0]  out_rd;
  logic        illegal;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [3:0]  sel;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;

  always #5 clk = ~clk;

  alu_issue_stage #(.XLEN(32), .RESET_PC_LINK(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .rd(rd),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm), .pc(pc),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .alu_x(alu_x), .alu_y(alu_y), .alu_sel(alu_sel), .out_rd(out_rd),
    .illegal(illegal)
  );

  task automatic check(input string nm, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Instruction-level reference: what alu32 should be asked to do.
  function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [4:0] d, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] im, input logic [31:0] p);
    exp_t e;
    e = '0;
    e.rd = d;
    case (op)
      7'h33: begin
        e.x = a; e.y = b; e.sel = {f7[5], f3};
        e.ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
      end
      7'h13: begin
        e.x = a; e.y = im; e.sel = {(f3 == 3'd5) ? f7[5] : 1'b0, f3};
        e.ill = (f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
      end
      7'h37:        begin e.x = 0;  e.y = im; e.sel = 4'hF; end
      7'h17:        begin e.x = p;  e.y = im; end
      7'h6F, 7'h67: begin e.x = p;  e.y = 32'd4; end
      7'h03, 7'h23: begin e.x = a;  e.y = im; end
      7'h63:        begin e.x = a;  e.y = b; e.sel = 4'h8; end
      default:      e.ill = 1'b1;
    endcase
    return e;
  endfunction

  // Monitor compares against queue head, then predicts the state after the next edge.
  always @(negedge clk) begin
    bit acc;
    if (mon_en) begin
      check("out_valid", 80'(out_valid), 80'(q.size() != 0));
      check("in_ready", 80'(in_ready), 80'((q.size() == 0) || out_ready));
      if (out_valid && q.size() != 0)
        check("bundle", 80'({alu_x, alu_y, alu_sel, out_rd, illegal}), 80'(q[0]));
      if (rst || flush) q.delete();
      else begin
        acc = in_valid && (q.size() == 0 || out_ready);
        if (q.size() != 0 && out_ready) void'(q.pop_front());
        if (acc) q.push_back(model(opcode, funct3, funct7, rd, rs1_val, rs2_val, imm, pc));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [4:0] d, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] im, input logic [31:0] p);
    opcode = op; funct3 = f3; funct7 = f7; rd = d;
    rs1_val = a; rs2_val = b; imm = im; pc = p;
  endtask

  function automatic logic [6:0] rand_op();
    case ($urandom_range(0, 9))
      0: return 7'h33; 1: return 7'h13; 2: return 7'h37; 3: return 7'h17;
      4: return 7'h6F; 5: return 7'h67; 6: return 7'h03; 7: return 7'h23;
      8: return 7'h63;
      default: return 7'($urandom);
    endcase
  endfunction

  function automatic logic [6:0] rand_f7();
    case ($urandom_range(0, 3))
      0, 1: return 7'h00;
      2:    return 7'h20;
      default: return 7'($urandom);
    endcase
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    set_instr(7'h00, 3'd0, 7'h00, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_state", 80'({out_valid, alu_x, alu_y, alu_sel, out_rd, illegal}), 80'd0);
    check("rst_in_ready", 80'(in_ready), 80'd1);
    step();
    mon_en = 1'b1;

    // Back-to-back directed encodings
    out_ready = 1'b1; in_valid = 1'b1;
    set_instr(7'h33, 3'd0, 7'h00, 5'd1, 32'd10, 32'd20, 32'd0, 32'd0);
    step();
    check("add_sum", 80'(alu_x + alu_y), 80'd30);
    set_instr(7'h13, 3'd5, 7'h20, 5'd2, 32'hFFFF_FFF0, 32'd0, 32'd1, 32'd0);
    step();
    check("srai_sel", 80'({alu_sel, alu_y, illegal}), 80'({4'b1101, 32'd1, 1'b0}));
    set_instr(7'h33, 3'd6, 7'h20, 5'd3, 32'd5, 32'd6, 32'd0, 32'd0);
    step();
    check("op_bad_f7", 80'({out_valid, illegal}), 80'({1'b1, 1'b1}));
    set_instr(7'h7F, 3'd0, 7'h00, 5'd4, 32'd7, 32'd8, 32'd9, 32'd10);
    step();
    check("bad_opcode", 80'({illegal, alu_x, alu_y}), 80'({1'b1, 32'd0, 32'd0}));
    set_instr(7'h37, 3'd0, 7'h00, 5'd5, 32'd1, 32'd2, 32'h1234_5000, 32'd0);
    step();
    check("lui", 80'({alu_sel, alu_y}), 80'({4'hF, 32'h1234_5000}));
    in_valid = 1'b0;
    step();

    // Stall: bundle held while downstream is not ready
    out_ready = 1'b0; in_valid = 1'b1;
    set_instr(7'h63, 3'd1, 7'h00, 5'd6, 32'd100, 32'd40, 32'd0, 32'd0);
    step();
    set_instr(7'h6F, 3'd0, 7'h00, 5'd7, 32'd0, 32'd0, 32'd0, 32'h0000_1000);
    step(); step(); step();
    check("stall_ready", 80'({in_ready, alu_x, alu_sel}), 80'({1'b0, 32'd100, 4'h8}));
    out_ready = 1'b1;
    step();
    check("stall_release", 80'({alu_x, alu_y, out_rd}), 80'({32'h1000, 32'd4, 5'd7}));
    in_valid = 1'b0;
    step();

    // Flush a stalled bundle together with an incoming one
    out_ready = 1'b0; in_valid = 1'b1;
    set_instr(7'h17, 3'd0, 7'h00, 5'd8, 32'd0, 32'd0, 32'd16, 32'd32);
    step(); step();
    flush = 1'b1;
    set_instr(7'h03, 3'd2, 7'h00, 5'd9, 32'd1, 32'd2, 32'd3, 32'd4);
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush", 80'({out_valid, illegal}), 80'd0);
    step();

    // Reset while holding a valid bundle
    in_valid = 1'b1;
    set_instr(7'h23, 3'd2, 7'h00, 5'd10, 32'hAAAA_0000, 32'd0, 32'h55, 32'd0);
    step();
    check("pre_rst_valid", 80'(out_valid), 80'd1);
    in_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst", 80'({out_valid, alu_x, alu_y, alu_sel, out_rd, illegal}), 80'd0);
    step();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 99) < 3);
      set_instr(rand_op(), 3'($urandom), rand_f7(), 5'($urandom),
                $urandom, $urandom, $urandom, $urandom);
      step();
    end

    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 5 && q.size() != 0; i++) step();
    step();
    check("drain", 80'(q.size()), 80'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
